sp_stack_ctrl: RTL and testbench

Stack sequencer that drives the command side of the SP stack-pointer register (SPDrive/SPSet) and consumes its SPOutput. It turns single-cycle PUSH/POP/LOAD requests from the CPU core into ordered SP updates plus stack-RAM accesses. It also enforces the configured stack bounds. It sits between instruction control, the SP register and the data-memory port.

---
 rtl/sp_stack_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_sp_stack_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sp_stack_ctrl.sv
// Stack sequencer: turns PUSH/POP/LOAD requests into ordered SP register commands
// and stack-RAM accesses for a full-descending stack, enforcing the configured bounds.
module sp_stack_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] STACK_TOP  = 32'h0000_1000,
    parameter logic [ADDR_W-1:0] STACK_BASE = 32'h0000_0F00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              OpValid,
    input  logic [1:0]        OpCode,
    input  logic [DATA_W-1:0] OpData,
    output logic              OpReady,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] PopData,
    output logic              Overflow,
    output logic              Underflow,
    output logic [1:0]        SPDrive,
    output logic [ADDR_W-1:0] SPSet,
    input  logic [ADDR_W-1:0] SPOutput,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWe,
    output logic              MemRe,
    input  logic [DATA_W-1:0] MemRData
);

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;
    localparam logic [1:0] SP_LOAD = 2'b11;

    // LOAD bound checks are done at the wider of the two widths so nothing truncates.
    localparam int CW = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [CW-1:0] TOP_C  = CW'(STACK_TOP);
    localparam logic [CW-1:0] BASE_C = CW'(STACK_BASE);

    typedef enum logic [3:0] {
        S_INIT,
        S_INIT_W,
        S_IDLE,
        S_PUSH_DEC,
        S_PUSH_WR,
        S_POP_RD,
        S_POP_CAP,
        S_LOAD_SET,
        S_LOAD_W
    } state_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic        accept;
    logic        set_ovf, set_unf, cap_pop;
    logic [CW-1:0] ld_val;

    assign accept = OpValid && OpReady;
    assign ld_val = CW'(req_q.data);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            req_q     <= '0;
            PopData   <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q.op   <= OpCode;
                req_q.data <= OpData;
            end
            if (cap_pop) PopData   <= MemRData;
            if (set_ovf) Overflow  <= 1'b1;
            if (set_unf) Underflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        OpReady   = 1'b0;
        Done      = 1'b0;
        Err       = 1'b0;
        SPDrive   = SP_HOLD;
        SPSet     = '0;
        MemAddr   = '0;
        MemWData  = '0;
        MemWe     = 1'b0;
        MemRe     = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        cap_pop   = 1'b0;

        case (state)
            S_INIT: begin
                // Gated so the SP load command stays quiet while reset is held.
                if (rst_n) begin
                    SPDrive = SP_LOAD;
                    SPSet   = STACK_TOP;
                end
                state_nxt = S_INIT_W;
            end
            S_INIT_W: state_nxt = S_IDLE;
            S_IDLE: begin
                OpReady = 1'b1;
                if (OpValid) begin
                    case (OpCode)
                        OP_PUSH: state_nxt = S_PUSH_DEC;
                        OP_POP:  state_nxt = S_POP_RD;
                        OP_LOAD: state_nxt = S_LOAD_SET;
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_PUSH_DEC: begin
                if (SPOutput == STACK_BASE) begin
                    Done      = 1'b1;
                    Err       = 1'b1;
                    set_ovf   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    SPDrive   = SP_DEC;
                    state_nxt = S_PUSH_WR;
                end
            end
            S_PUSH_WR: begin
                // SP already reflects the pre-decrement issued last cycle.
                MemWe     = 1'b1;
                MemAddr   = SPOutput;
                MemWData  = req_q.data;
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_POP_RD: begin
                if (SPOutput == STACK_TOP) begin
                    Done      = 1'b1;
                    Err       = 1'b1;
                    set_unf   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    MemRe     = 1'b1;
                    MemAddr   = SPOutput;
                    SPDrive   = SP_INC;
                    state_nxt = S_POP_CAP;
                end
            end
            S_POP_CAP: begin
                cap_pop   = 1'b1;
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_LOAD_SET: begin
                if (ld_val > TOP_C) begin
                    Done      = 1'b1;
                    Err       = 1'b1;
                    set_ovf   = 1'b1;
                    state_nxt = S_IDLE;
                end else if (ld_val < BASE_C) begin
                    Done      = 1'b1;
                    Err       = 1'b1;
                    set_unf   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    SPDrive   = SP_LOAD;
                    SPSet     = ADDR_W'(req_q.data);
                    state_nxt = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_sp_stack_ctrl.sv
// Bench for sp_stack_ctrl: SP register and stack RAM models, directed table of the
// main scenarios, randomized ops against a stack model, and reset abort checks.
module tb_sp_stack_ctrl;

    localparam logic [31:0] TOP  = 32'd16;
    localparam logic [31:0] BASE = 32'd12;
    localparam logic [1:0]  NOP = 2'b00, PUSH = 2'b01, POP = 2'b10, LOAD = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        OpValid = 1'b0;
    logic [1:0]  OpCode = 2'b00;
    logic [31:0] OpData = 32'd0;
    logic        OpReady, Done, Err, Overflow, Underflow, MemWe, MemRe;
    logic [31:0] PopData, SPSet, MemAddr, MemWData;
    logic [1:0]  SPDrive;
    logic [31:0] sp_q = 32'd0;
    logic [31:0] rdata = 32'd0;
    logic [31:0] ram [0:255];

    int n_cmp = 0;
    int n_bad = 0;

    sp_stack_ctrl #(.DATA_W(32), .ADDR_W(32), .STACK_TOP(TOP), .STACK_BASE(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .OpValid(OpValid), .OpCode(OpCode), .OpData(OpData),
        .OpReady(OpReady), .Done(Done), .Err(Err), .PopData(PopData),
        .Overflow(Overflow), .Underflow(Underflow), .SPDrive(SPDrive), .SPSet(SPSet),
        .SPOutput(sp_q), .MemAddr(MemAddr), .MemWData(MemWData), .MemWe(MemWe),
        .MemRe(MemRe), .MemRData(rdata)
    );

    always #5 clk = ~clk;

    // SP register (no reset) and synchronous stack RAM
    always @(posedge clk) begin
        case (SPDrive)
            2'b01: sp_q <= sp_q + 32'd1;
            2'b10: sp_q <= sp_q - 32'd1;
            2'b11: sp_q <= SPSet;
            default: ;
        endcase
        if (MemWe) ram[MemAddr[7:0]] <= MemWData;
        if (MemRe) rdata <= ram[MemAddr[7:0]];
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        int          lat;   // 0: no Done expected (NOP)
        logic        err, we, re, ld;
        logic [31:0] addr, wdata, sp, pop;
        logic        ovf, unf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("one_strobe", 32'(MemWe && MemRe), 32'd0);
            chk("err_qual", 32'(Err && !Done), 32'd0);
        end
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [31:0] data, input int lat,
                                input logic err, input logic we, input logic re, input logic ld,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] sp, input logic [31:0] pop,
                                input logic ovf, input logic unf);
        vec_t v;
        v.op = op; v.data = data; v.lat = lat; v.err = err; v.we = we; v.re = re; v.ld = ld;
        v.addr = addr; v.wdata = wdata; v.sp = sp; v.pop = pop; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    // Issue one request (starting at a negedge) and check everything it should do.
    task automatic do_op(input vec_t v, input string nm);
        int n = 0;
        bit done = 0, we = 0, re = 0, ld = 0;
        int lat = 0;
        logic err = 1'b0;
        logic [31:0] wa = 0, wd = 0, ra = 0, ls = 0;
        while (!OpReady && n < 10) begin @(negedge clk); n++; end
        chk({nm, ":ready"}, 32'(OpReady), 32'd1);
        if (!OpReady) return;
        OpValid = 1'b1; OpCode = v.op; OpData = v.data;
        @(posedge clk); #1;
        OpValid = 1'b0; OpCode = 2'($urandom); OpData = $urandom;
        for (int c = 1; c <= 3 && !done; c++) begin
            @(negedge clk);
            if (MemWe) begin we = 1; wa = MemAddr; wd = MemWData; end
            if (MemRe) begin re = 1; ra = MemAddr; end
            if (SPDrive == 2'b11) begin ld = 1; ls = SPSet; end
            if (Done) begin done = 1; lat = c; err = Err; end
        end
        if (v.lat == 0) begin
            chk({nm, ":nop_done"}, 32'(done), 32'd0);
            chk({nm, ":nop_mem"}, 32'(we || re || ld), 32'd0);
            return;
        end
        chk({nm, ":lat"}, 32'(lat), 32'(v.lat));
        chk({nm, ":err"}, 32'(err), 32'(v.err));
        chk({nm, ":we"}, 32'(we), 32'(v.we));
        chk({nm, ":re"}, 32'(re), 32'(v.re));
        chk({nm, ":ld"}, 32'(ld), 32'(v.ld));
        if (v.we) begin chk({nm, ":waddr"}, wa, v.addr); chk({nm, ":wdata"}, wd, v.wdata); end
        if (v.re) chk({nm, ":raddr"}, ra, v.addr);
        if (v.ld) chk({nm, ":spset"}, ls, v.data);
        @(negedge clk);
        chk({nm, ":sp"}, sp_q, v.sp);
        chk({nm, ":popdata"}, PopData, v.pop);
        chk({nm, ":ovf"}, 32'(Overflow), 32'(v.ovf));
        chk({nm, ":unf"}, 32'(Underflow), 32'(v.unf));
    endtask

    // Reset (optionally in the middle of an accepted PUSH) and check the init sequence.
    task automatic do_reset(input bit mid_push);
        if (mid_push) begin
            int n = 0;
            while (!OpReady && n < 10) begin @(negedge clk); n++; end
            OpValid = 1'b1; OpCode = PUSH; OpData = 32'h5A;
            @(posedge clk); #1;
            OpValid = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst:we", 32'(MemWe), 32'd0);
        end
        chk("rst:ready", 32'(OpReady), 32'd0);
        chk("rst:spdrive", 32'(SPDrive), 32'd0);
        chk("rst:spset", SPSet, 32'd0);
        chk("rst:done", 32'({Done, Err, MemRe}), 32'd0);
        chk("rst:memaddr", MemAddr | MemWData, 32'd0);
        chk("rst:popdata", PopData, 32'd0);
        chk("rst:flags", 32'({Overflow, Underflow}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("init:spdrive", 32'(SPDrive), 32'd3);
        chk("init:spset", SPSet, TOP);
        chk("init:ready0", 32'(OpReady), 32'd0);
        @(negedge clk);
        chk("initw:spdrive", 32'(SPDrive), 32'd0);
        chk("initw:sp", sp_q, TOP);
        chk("initw:ready0", 32'(OpReady), 32'd0);
        @(negedge clk);
        chk("idle:ready", 32'(OpReady), 32'd1);
        chk("idle:we", 32'(MemWe), 32'd0);
        chk("idle:sp", sp_q, TOP);
        chk("idle:flags", 32'({Overflow, Underflow}), 32'd0);
    endtask

    // Reference model: word-addressed stack memory, SP, sticky flags
    logic [31:0] ref_mem [0:255];
    logic [31:0] sp_m, pop_m;
    logic        ovf_m, unf_m;

    function automatic vec_t model(input logic [1:0] op, input logic [31:0] d);
        vec_t v = mk(op, d, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        case (op)
            PUSH: if (sp_m == BASE) begin v.lat = 1; v.err = 1; ovf_m = 1; end
                  else begin
                      sp_m = sp_m - 1; v.we = 1; v.addr = sp_m; v.wdata = d;
                      ref_mem[sp_m[7:0]] = d;
                  end
            POP:  if (sp_m == TOP) begin v.lat = 1; v.err = 1; unf_m = 1; end
                  else begin
                      v.re = 1; v.addr = sp_m; pop_m = ref_mem[sp_m[7:0]]; sp_m = sp_m + 1;
                  end
            LOAD: if (d > TOP) begin v.lat = 1; v.err = 1; ovf_m = 1; end
                  else if (d < BASE) begin v.lat = 1; v.err = 1; unf_m = 1; end
                  else begin v.ld = 1; sp_m = d; end
            default: v.lat = 0;
        endcase
        v.sp = sp_m; v.pop = pop_m; v.ovf = ovf_m; v.unf = unf_m;
        return v;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        for (int i = 0; i < 256; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end

        // Randomized ops against the model, starting from a fresh reset
        do_reset(1'b0);
        sp_m = TOP; pop_m = 0; ovf_m = 0; unf_m = 0;
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  op;
            logic [31:0] d;
            op = 2'($urandom_range(0, 3));
            d  = (op == LOAD) ? (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0
                                                            : 32'($urandom_range(8, 20)))
                              : $urandom;
            do_op(model(op, d), "rand");
        end

        // Directed table
        do_reset(1'b0);
        tbl.push_back(mk(PUSH, 32'hA1, 2, 0, 1, 0, 0, 15, 32'hA1, 15, 0, 0, 0));
        tbl.push_back(mk(PUSH, 32'hB2, 2, 0, 1, 0, 0, 14, 32'hB2, 14, 0, 0, 0));
        tbl.push_back(mk(PUSH, 32'hC3, 2, 0, 1, 0, 0, 13, 32'hC3, 13, 0, 0, 0));
        tbl.push_back(mk(POP,  0,      2, 0, 0, 1, 0, 13, 0, 14, 32'hC3, 0, 0));
        tbl.push_back(mk(POP,  0,      2, 0, 0, 1, 0, 14, 0, 15, 32'hB2, 0, 0));
        tbl.push_back(mk(POP,  0,      2, 0, 0, 1, 0, 15, 0, 16, 32'hA1, 0, 0));
        tbl.push_back(mk(POP,  0,      1, 1, 0, 0, 0, 0, 0, 16, 32'hA1, 0, 1));
        tbl.push_back(mk(PUSH, 32'd1,  2, 0, 1, 0, 0, 15, 1, 15, 32'hA1, 0, 1));
        tbl.push_back(mk(PUSH, 32'd2,  2, 0, 1, 0, 0, 14, 2, 14, 32'hA1, 0, 1));
        tbl.push_back(mk(PUSH, 32'd3,  2, 0, 1, 0, 0, 13, 3, 13, 32'hA1, 0, 1));
        tbl.push_back(mk(PUSH, 32'd4,  2, 0, 1, 0, 0, 12, 4, 12, 32'hA1, 0, 1));
        tbl.push_back(mk(PUSH, 32'd5,  1, 1, 0, 0, 0, 0, 0, 12, 32'hA1, 1, 1));
        tbl.push_back(mk(LOAD, 32'd20, 1, 1, 0, 0, 0, 0, 0, 12, 32'hA1, 1, 1));
        tbl.push_back(mk(LOAD, 32'd14, 2, 0, 0, 0, 1, 0, 0, 14, 32'hA1, 1, 1));
        tbl.push_back(mk(LOAD, 32'd11, 1, 1, 0, 0, 0, 0, 0, 14, 32'hA1, 1, 1));
        tbl.push_back(mk(NOP,  32'd7,  0, 0, 0, 0, 0, 0, 0, 14, 32'hA1, 1, 1));
        tbl.push_back(mk(POP,  0,      2, 0, 0, 1, 0, 14, 0, 15, 32'd2, 1, 1));
        tbl.push_back(mk(LOAD, 32'd12, 2, 0, 0, 0, 1, 0, 0, 12, 32'd2, 1, 1));
        tbl.push_back(mk(LOAD, 32'd16, 2, 0, 0, 0, 1, 0, 0, 16, 32'd2, 1, 1));
        foreach (tbl[i]) do_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while an accepted PUSH sits in its decrement cycle
        do_reset(1'b1);
        do_op(mk(PUSH, 32'hEE, 2, 0, 1, 0, 0, 15, 32'hEE, 15, 0, 0, 0), "post_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
